// File: rtl/seg_mem_banked_if.sv
// seg_mem_banked_if: per-bank access ports and dump-engine stream of seg_mem_banked
interface seg_mem_banked_if #(
  parameter int N_BANKS = 3,
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 10
);
  logic [N_BANKS-1:0]        re;
  logic [N_BANKS-1:0]        we;
  logic [N_BANKS*ADDR_W-1:0] addr;
  logic [N_BANKS*DATA_W-1:0] wd;
  logic [N_BANKS*DATA_W-1:0] rd;
  logic [N_BANKS-1:0]        rd_valid;
  logic [N_BANKS-1:0]        oor_err;
  logic                      dump_start;
  logic                      dump_busy;
  logic                      dump_valid;
  logic                      dump_ready;
  logic [ADDR_W-1:0]         dump_addr;
  logic [DATA_W-1:0]         dump_data;
  logic                      dump_last;
  logic                      dirty;
  modport master (
    output re, we, addr, wd, dump_start, dump_ready,
    input  rd, rd_valid, oor_err, dump_busy, dump_valid, dump_addr, dump_data, dump_last, dirty
  );
  modport slave (
    input  re, we, addr, wd, dump_start, dump_ready,
    output rd, rd_valid, oor_err, dump_busy, dump_valid, dump_addr, dump_data, dump_last, dirty
  );
endinterface

// File: rtl/seg_mem_banked.sv
// seg_mem_banked: N_BANKS registered-read banks with range checking, plus a dump engine streaming DUMP_BANK
module seg_mem_banked #(
  parameter int N_BANKS   = 3,
  parameter int DATA_W    = 24,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int DUMP_BANK = N_BANKS - 1
) (
  input logic clk,
  input logic rst_n,
  seg_mem_banked_if.slave bus
);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
  logic [DATA_W-1:0]              mem [N_BANKS][DEPTH];
  logic [ADDR_W-1:0]              a [N_BANKS];
  logic [DATA_W-1:0]              d [N_BANKS];
  logic [N_BANKS-1:0]             in_rng, wr;
  logic [N_BANKS-1:0][DATA_W-1:0] rd_q;
  logic [N_BANKS-1:0]             rd_valid_q, oor_q;
  state_t                         state_q;
  logic [ADDR_W-1:0]              ptr_q;
  logic [DATA_W-1:0]              data_q;
  logic                           busy_q, valid_q, last_q, dirty_q, dirty_d, accept;
  for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
    assign a[g]      = bus.addr[g*ADDR_W +: ADDR_W];
    assign d[g]      = bus.wd[g*DATA_W +: DATA_W];
    assign in_rng[g] = {1'b0, a[g]} < DEPTH_C;
  end
  assign wr      = bus.we & in_rng;
  assign accept  = bus.dump_start && state_q == IDLE;
  // a write landing on the accepting edge must keep the bank marked dirty
  assign dirty_d = wr[DUMP_BANK] | (dirty_q & ~accept);
  // arrays carry no reset so contents survive rst_n
  always_ff @(posedge clk)
    for (int b = 0; b < N_BANKS; b++)
      if (wr[b]) mem[b][a[b]] <= d[b];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q       <= '0;
      rd_valid_q <= '0;
      oor_q      <= '0;
    end else begin
      rd_valid_q <= bus.re;
      oor_q      <= (bus.re | bus.we) & ~in_rng;
      for (int b = 0; b < N_BANKS; b++)
        if (bus.re[b]) rd_q[b] <= in_rng[b] ? mem[b][a[b]] : '0;
    end
  // private read port: sampled in FETCH, then held through SEND until accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      unique case (state_q)
        IDLE: if (bus.dump_start) begin
          state_q <= FETCH;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
        FETCH: begin
          data_q  <= mem[DUMP_BANK][ptr_q];
          last_q  <= ptr_q == LAST_C;
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (bus.dump_ready) begin
          valid_q <= 1'b0;
          state_q <= last_q ? IDLE : FETCH;
          busy_q  <= ~last_q;
          ptr_q   <= last_q ? ptr_q : ptr_q + ADDR_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.rd         = rd_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.oor_err    = oor_q;
  assign bus.dump_busy  = busy_q;
  assign bus.dump_valid = valid_q;
  assign bus.dump_addr  = ptr_q;
  assign bus.dump_data  = data_q;
  assign bus.dump_last  = last_q;
  assign bus.dirty      = dirty_q;
endmodule

// File: tb/tb_seg_mem_banked.sv
// tb_seg_mem_banked: table vectors, randomized port traffic vs an array model, and dump-engine sequences
module tb_seg_mem_banked;
  localparam int NB = 3, DW = 24, D = 100, AW = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seg_mem_banked_if #(.N_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) bus();
  seg_mem_banked #(.N_BANKS(NB), .DATA_W(DW), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_vec = 0, n_err = 0;
  logic [DW-1:0] mem_m [NB][D];
  logic [DW-1:0] rd_m [NB];
  logic [NB-1:0] rv_m = '0, oor_m = '0;
  typedef struct {
    int b; logic r; logic w; int a; logic [DW-1:0] d;
    logic [DW-1:0] ex_rd; logic ex_v; logic ex_oor;
  } vec_t;
  vec_t tv [11];
  function automatic logic [DW-1:0] pre(int b, int a);
    return DW'(b * 'h100000 + a * 'h101 + 1);
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic idle_ports();
    bus.re = '0;
    bus.we = '0;
  endtask
  task automatic drive(int b, logic r, logic w, int a, logic [DW-1:0] d);
    bus.re[b] = r;
    bus.we[b] = w;
    bus.addr[b*AW +: AW] = AW'(a);
    bus.wd[b*DW +: DW] = d;
  endtask
  task automatic step();
    for (int b = 0; b < NB; b++) begin
      int a;
      a = int'(bus.addr[b*AW +: AW]);
      rv_m[b]  = bus.re[b];
      oor_m[b] = (bus.re[b] | bus.we[b]) && a >= D;
      if (bus.re[b]) rd_m[b] = a < D ? mem_m[b][a] : '0;
      if (bus.we[b] && a < D) mem_m[b][a] = bus.wd[b*DW +: DW];
    end
    @(posedge clk);
    #1;
  endtask
  task automatic chk_ports(string nm);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("%s_rd%0d", nm, b), 32'(bus.rd[b*DW +: DW]), 32'(rd_m[b]));
      chk($sformatf("%s_rv%0d", nm, b), 32'(bus.rd_valid[b]), 32'(rv_m[b]));
      chk($sformatf("%s_oor%0d", nm, b), 32'(bus.oor_err[b]), 32'(oor_m[b]));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int cyc, beat, first_v;
    logic [DW-1:0] old0;
    bus.re = '0; bus.we = '0; bus.addr = '0; bus.wd = '0;
    bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    for (int b = 0; b < NB; b++) rd_m[b] = '0;
    #12;
    chk("rst_rd", 32'(bus.rd != '0), 0);
    chk("rst_rv", 32'(bus.rd_valid), 0);
    chk("rst_oor", 32'(bus.oor_err), 0);
    chk("rst_busy", 32'(bus.dump_busy), 0);
    chk("rst_valid", 32'(bus.dump_valid), 0);
    chk("rst_daddr", 32'(bus.dump_addr), 0);
    chk("rst_ddata", 32'(bus.dump_data), 0);
    chk("rst_last", 32'(bus.dump_last), 0);
    chk("rst_dirty", 32'(bus.dirty), 0);
    rst_n = 1'b1;
    for (int a = 0; a < D; a++) begin
      for (int b = 0; b < NB; b++) drive(b, 1'b0, 1'b1, a, pre(b, a));
      step();
    end
    idle_ports();
    chk("preload_dirty", 32'(bus.dirty), 1);
    tv[0]  = '{1, 1'b0, 1'b1, 5,   24'h00ABCD, 24'h000000, 1'b0, 1'b0};
    tv[1]  = '{1, 1'b1, 1'b0, 5,   24'h000000, 24'h00ABCD, 1'b1, 1'b0};
    tv[2]  = '{1, 1'b0, 1'b0, 0,   24'h000000, 24'h00ABCD, 1'b0, 1'b0};
    tv[3]  = '{0, 1'b0, 1'b1, 3,   24'h111111, 24'h000000, 1'b0, 1'b0};
    tv[4]  = '{0, 1'b1, 1'b1, 3,   24'h222222, 24'h111111, 1'b1, 1'b0};
    tv[5]  = '{0, 1'b1, 1'b0, 3,   24'h000000, 24'h222222, 1'b1, 1'b0};
    tv[6]  = '{2, 1'b1, 1'b0, 99,  24'h000000, pre(2, 99), 1'b1, 1'b0};
    tv[7]  = '{2, 1'b0, 1'b1, 100, 24'h00DEAD, pre(2, 99), 1'b0, 1'b1};
    tv[8]  = '{2, 1'b1, 1'b0, 100, 24'h000000, 24'h000000, 1'b1, 1'b1};
    tv[9]  = '{2, 1'b1, 1'b0, 99,  24'h000000, pre(2, 99), 1'b1, 1'b0};
    tv[10] = '{2, 1'b1, 1'b1, 127, 24'h00BEEF, 24'h000000, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      idle_ports();
      drive(tv[i].b, tv[i].r, tv[i].w, tv[i].a, tv[i].d);
      step();
      chk($sformatf("vec%0d_rd", i), 32'(bus.rd[tv[i].b*DW +: DW]), 32'(tv[i].ex_rd));
      chk($sformatf("vec%0d_rv", i), 32'(bus.rd_valid), 32'(tv[i].ex_v) << tv[i].b);
      chk($sformatf("vec%0d_oor", i), 32'(bus.oor_err), 32'(tv[i].ex_oor) << tv[i].b);
    end
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < NB; b++)
        drive(b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 127)), DW'($urandom));
      step();
      chk_ports($sformatf("rnd%0d", i));
    end
    idle_ports();
    drive(2, 1'b0, 1'b1, 10, 24'h5A5A5A);
    step();
    idle_ports();
    chk("dirty_set", 32'(bus.dirty), 1);
    bus.dump_start = 1'b1;
    bus.dump_ready = 1'b1;
    step();
    bus.dump_start = 1'b0;
    chk("a_busy_rise", 32'(bus.dump_busy), 1);
    chk("a_valid_early", 32'(bus.dump_valid), 0);
    chk("a_dirty_clr", 32'(bus.dirty), 0);
    cyc = 0; beat = 0; first_v = -1;
    while (bus.dump_busy && cyc < 400) begin
      if (bus.dump_valid) begin
        if (first_v < 0) first_v = cyc;
        chk("a_addr", 32'(bus.dump_addr), 32'(beat));
        chk("a_data", 32'(bus.dump_data), 32'(mem_m[2][beat]));
        chk("a_last", 32'(bus.dump_last), 32'(beat == D - 1));
        beat++;
      end
      step();
      cyc++;
    end
    chk("a_first_valid_cyc", 32'(first_v), 1);
    chk("a_beats", 32'(beat), D);
    chk("a_cycles", 32'(cyc), 2 * D);
    chk("a_valid_end", 32'(bus.dump_valid), 0);
    bus.dump_start = 1'b1;
    bus.dump_ready = 1'b0;
    step();
    bus.dump_start = 1'b0;
    cyc = 0; beat = 0;
    while (bus.dump_busy && cyc < 2000) begin
      bus.dump_start = cyc == 37 || cyc == 150;
      bus.dump_ready = 1'($urandom);
      if (bus.dump_valid) begin
        chk("b_addr", 32'(bus.dump_addr), 32'(beat));
        chk("b_data", 32'(bus.dump_data), 32'(mem_m[2][beat]));
        chk("b_last", 32'(bus.dump_last), 32'(beat == D - 1));
        if (bus.dump_ready) beat++;
      end
      step();
      cyc++;
    end
    bus.dump_start = 1'b0;
    chk("b_done_in_budget", 32'(cyc < 2000), 1);
    chk("b_beats", 32'(beat), D);
    step();
    chk("b_no_restart", 32'(bus.dump_busy), 0);
    drive(2, 1'b0, 1'b1, 7, 24'h777777);
    bus.dump_start = 1'b1;
    step();
    idle_ports();
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;
    chk("c_dirty_coincident", 32'(bus.dirty), 1);
    chk("c_busy", 32'(bus.dump_busy), 1);
    old0 = mem_m[2][0];
    drive(2, 1'b0, 1'b1, 0, 24'h0F0F0F);
    step();
    idle_ports();
    chk("c_valid", 32'(bus.dump_valid), 1);
    chk("c_fetch_old_data", 32'(bus.dump_data), 32'(old0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("c_rst_valid", 32'(bus.dump_valid), 0);
    chk("c_rst_busy", 32'(bus.dump_busy), 0);
    chk("c_rst_dirty", 32'(bus.dirty), 0);
    for (int b = 0; b < NB; b++) rd_m[b] = '0;
    rv_m = '0;
    oor_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(2, 1'b1, 1'b0, 7, 24'h0);
    step();
    chk_ports("c_keep7");
    drive(2, 1'b1, 1'b0, 0, 24'h0);
    step();
    chk_ports("c_keep0");
    idle_ports();
    step();
    chk("c_not_resumed", 32'(bus.dump_busy), 0);
    chk("c_valid_after", 32'(bus.dump_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
